// File: rtl/seg7_pkg.sv
// Shared seven-segment constants (active-low, bit6=a .. bit0=g) and the
// scan decoder's FSM state type. The forward encoder uses the same table.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

endpackage

// File: rtl/seg7_inv.sv
// Inverse glyph lookup: active-low segment pattern -> hex nibble.
// hit_o flags a legal hex glyph; blank_o flags an all-off pattern.
module seg7_inv
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       hit_o,
    output logic       blank_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        hit_o    = 1'b0;
        nibble_o = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG_HEX[i]) begin
                hit_o    = 1'b1;
                nibble_o = 4'(i);
            end
        end
    end

    assign blank_o = (seg_i == SEG_BLANK);

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed active-low 7-segment bus and reconstructs the nibble
// shown on each digit once the strobe and segments have been steady long enough.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 16,
    parameter int IDX_W      = $clog2(NDIG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NDIG-1:0]   an,
    input  logic [6:0]        seg,
    output logic [4*NDIG-1:0] value,
    output logic [NDIG-1:0]   valid,
    output logic              upd,
    output logic [IDX_W-1:0]  upd_idx,
    output logic              err,
    output logic              frame_done,
    output state_e            state_dbg
);

    localparam int               CNT_W   = $clog2(STABLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);
    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYC - 1);

    logic [NDIG-1:0]   an_m_q, an_s_q, an_p_q;
    logic [6:0]        seg_m_q, seg_s_q, seg_p_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    state_e            state_q, state_d;
    logic [4*NDIG-1:0] value_q, value_d;
    logic [NDIG-1:0]   valid_q, valid_d, seen_q, seen_d;
    logic              upd_q, upd_d, err_q, err_d, frame_q, frame_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic              changed, one_hot, capture, hit, blank;
    logic [3:0]        nibble, zeros;
    logic [IDX_W-1:0]  low_idx;
    logic [NDIG-1:0]   seen_set;

    seg7_inv u_inv (
        .seg_i    (seg_s_q),
        .hit_o    (hit),
        .blank_o  (blank),
        .nibble_o (nibble)
    );

    assign changed = ({an_s_q, seg_s_q} != {an_p_q, seg_p_q});

    // Count low anodes; low_idx is only meaningful when exactly one is low.
    always_comb begin
        zeros   = 4'd0;
        low_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!an_s_q[i]) begin
                zeros   = zeros + 4'd1;
                low_idx = IDX_W'(i);
            end
        end
    end

    assign one_hot = (zeros == 4'd1);

    always_comb begin
        cnt_d   = changed ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1));
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (one_hot) state_d = SETTLE;
            end
            SETTLE: begin
                if (!one_hot) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_CAP && !changed) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (changed) state_d = one_hot ? SETTLE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        value_d  = value_q;
        valid_d  = valid_q;
        seen_d   = seen_q;
        idx_d    = idx_q;
        upd_d    = 1'b0;
        err_d    = 1'b0;
        frame_d  = 1'b0;
        seen_set = seen_q | (NDIG'(1) << low_idx);
        if (capture) begin
            upd_d            = 1'b1;
            idx_d            = low_idx;
            valid_d[low_idx] = hit;
            err_d            = !hit && !blank;
            if (hit) value_d[{low_idx, 2'b00} +: 4] = nibble;
            // The completing capture starts the next frame from an empty mask.
            if (&seen_set) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end else begin
                seen_d  = seen_set;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_m_q  <= '1;
            an_s_q  <= '1;
            an_p_q  <= '1;
            seg_m_q <= '1;
            seg_s_q <= '1;
            seg_p_q <= '1;
            cnt_q   <= '0;
            state_q <= IDLE;
            value_q <= '0;
            valid_q <= '0;
            seen_q  <= '0;
            idx_q   <= '0;
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            an_m_q  <= an;
            an_s_q  <= an_m_q;
            an_p_q  <= an_s_q;
            seg_m_q <= seg;
            seg_s_q <= seg_m_q;
            seg_p_q <= seg_s_q;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            value_q <= value_d;
            valid_q <= valid_d;
            seen_q  <= seen_d;
            idx_q   <= idx_d;
            upd_q   <= upd_d;
            err_q   <= err_d;
            frame_q <= frame_d;
        end
    end

    assign value      = value_q;
    assign valid      = valid_q;
    assign upd        = upd_q;
    assign upd_idx    = idx_q;
    assign err        = err_q;
    assign frame_done = frame_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder (NDIG=4, STABLE_CYC=4): history-based reference
// model checked every cycle, directed scenarios with literal expectations, random bus traffic.
module tb_seg7_scan_decoder;
    import seg7_pkg::*;

    localparam int NDIG       = 4;
    localparam int STABLE_CYC = 4;
    localparam int HN         = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  an  = 4'hF;
    logic [6:0]  seg = 7'h7F;
    logic [15:0] value;
    logic [3:0]  valid;
    logic        upd;
    logic [1:0]  upd_idx;
    logic        err;
    logic        frame_done;
    state_e      state_dbg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.NDIG(NDIG), .STABLE_CYC(STABLE_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .an         (an),
        .seg        (seg),
        .value      (value),
        .valid      (valid),
        .upd        (upd),
        .upd_idx    (upd_idx),
        .err        (err),
        .frame_done (frame_done),
        .state_dbg  (state_dbg)
    );

    // Glyph table transcribed from the display specification (active-low a..g).
    logic [6:0] glyph [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // 0..15 = glyph hit, 16 = blank, 17 = illegal
    function automatic int decode(input logic [6:0] s);
        for (int i = 0; i < 16; i++) if (glyph[i] == s) return i;
        return (s == 7'h7F) ? 16 : 17;
    endfunction

    // Reference model: a capture happens STABLE_CYC+2 edges after the first
    // sample of a one-hot run that lasts at least STABLE_CYC+1 samples.
    logic [10:0] hist [HN];
    int          k        = 0;
    int          last_rst = 0;
    bit          chk_en   = 1'b0;
    logic [15:0] m_value;
    logic [3:0]  m_valid, m_seen;
    logic [1:0]  m_idx;
    logic        m_upd, m_err, m_frame;

    always @(posedge clk) begin
        logic [10:0] p;
        bit          cap;
        int          d, idx, zeros;
        hist[k % HN] = rst ? 11'h7FF : {an, seg};
        m_upd   = 1'b0;
        m_err   = 1'b0;
        m_frame = 1'b0;
        if (rst) begin
            m_value  = '0;
            m_valid  = '0;
            m_seen   = '0;
            m_idx    = '0;
            last_rst = k;
            chk_en   = 1'b1;
        end else if (k - (STABLE_CYC + 2) > last_rst) begin
            p   = hist[(k - STABLE_CYC - 2) % HN];
            cap = (hist[(k - STABLE_CYC - 3) % HN] != p);
            for (int j = k - STABLE_CYC - 1; j <= k - 2; j++) if (hist[j % HN] != p) cap = 1'b0;
            zeros = 0;
            idx   = 0;
            for (int i = 0; i < NDIG; i++) if (!p[7 + i]) begin zeros++; idx = i; end
            if (zeros != 1) cap = 1'b0;
            if (cap) begin
                d     = decode(p[6:0]);
                m_upd = 1'b1;
                m_idx = idx[1:0];
                if (d < 16) begin
                    m_value[4*idx +: 4] = d[3:0];
                    m_valid[idx]        = 1'b1;
                end else begin
                    m_valid[idx] = 1'b0;
                    m_err        = (d == 17);
                end
                m_seen[idx] = 1'b1;
                if (m_seen == 4'hF) begin
                    m_frame = 1'b1;
                    m_seen  = '0;
                end
            end
        end
        k++;
    end

    int n_upd = 0, n_frame = 0, last_idx = 0, last_err = 0, frame_idx = -1;

    always @(negedge clk) begin
        if (chk_en) begin
            check("upd", upd, m_upd);
            check("err", err, m_err);
            check("frame_done", frame_done, m_frame);
            check("value", value, m_value);
            check("valid", valid, m_valid);
            if (m_upd) check("upd_idx", upd_idx, m_idx);
            if (upd) begin n_upd++; last_idx = upd_idx; last_err = err; end
            if (frame_done) begin n_frame++; frame_idx = upd ? int'(upd_idx) : -1; end
        end
    end

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(negedge clk);
    endtask

    // Called right after driving at a negedge; n = edges after the first sampling edge.
    task automatic wait_upd(output int n);
        n = 0;
        @(posedge clk);
        repeat (30) begin
            @(posedge clk);
            n++;
            #1;
            if (upd) return;
        end
        n = -1;
    endtask

    initial begin
        int n, u0, f0;
        logic [3:0] ra;
        logic [6:0] rs;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_value", value, 0);
        check("rst_valid", valid, 0);
        check("rst_upd", upd, 0);
        check("rst_err", err, 0);
        check("rst_frame", frame_done, 0);
        check("rst_idx", upd_idx, 0);
        check("rst_state", state_dbg, IDLE);

        // First capture latency from reset release
        rst = 1'b0;
        an  = 4'b1110;
        seg = 7'b0010010;
        wait_upd(n);
        check("lat_first", n, 2 + STABLE_CYC);
        check("first_nib", value[3:0], 4'h2);
        check("first_valid", valid, 4'b0001);
        check("first_err", err, 0);
        check("first_idx", upd_idx, 0);
        repeat (2) @(negedge clk);

        // Full scan: 7, A, d, F
        u0 = n_upd;
        f0 = n_frame;
        drive(4'b1110, 7'b0001111, 8);
        drive(4'b1101, 7'b0001000, 8);
        drive(4'b1011, 7'b1000010, 8);
        drive(4'b0111, 7'b0111000, 8);
        drive(4'b1111, 7'h7F, 4);
        check("scan_upds", n_upd - u0, 4);
        check("scan_frames", n_frame - f0, 1);
        check("scan_frame_idx", frame_idx, 3);
        check("scan_value", value, 16'hFDA7);
        check("scan_valid", valid, 4'hF);
        check("model_value", m_value, 16'hFDA7);

        // Segment glitching every 2 cycles never captures
        u0 = n_upd;
        for (int i = 0; i < 8; i++) drive(4'b1110, (i % 2) ? 7'b1001111 : 7'b0000001, 2);
        check("glitch_upds", n_upd - u0, 0);
        u0 = n_upd;
        drive(4'b1110, 7'b1001111, 10);
        check("settle_upds", n_upd - u0, 1);
        check("settle_nib", value[3:0], 4'h1);

        // Two anodes low: no capture, FSM idles
        u0 = n_upd;
        drive(4'b1100, 7'b0000110, 20);
        check("multi_upds", n_upd - u0, 0);
        check("multi_state", state_dbg, IDLE);

        // Illegal then blank on digit 2
        u0 = n_upd;
        drive(4'b1011, 7'b1111110, 10);
        check("ill_upds", n_upd - u0, 1);
        check("ill_idx", last_idx, 2);
        check("ill_err", last_err, 1);
        check("ill_valid2", valid[2], 0);
        check("ill_value2", value[11:8], 4'hD);
        u0 = n_upd;
        drive(4'b1011, 7'h7F, 10);
        check("blank_upds", n_upd - u0, 1);
        check("blank_err", last_err, 0);
        check("blank_valid2", valid[2], 0);

        // Reset while settling (cnt=2), then capture resumes
        an  = 4'b1110;
        seg = 7'b0000110;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_value", value, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_upd", upd, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_frame", frame_done, 0);
        check("mid_rst_idx", upd_idx, 0);
        rst = 1'b0;
        wait_upd(n);
        check("lat_after_rst", n, 2 + STABLE_CYC);
        check("after_rst_nib", value[3:0], 4'h3);
        @(negedge clk);

        // Random bus traffic
        repeat (300) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: ra = ~(4'(1) << $urandom_range(0, 3));
                6, 7:             ra = 4'hF;
                default:          ra = 4'($urandom_range(0, 15));
            endcase
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: rs = glyph[$urandom_range(0, 15)];
                6:                rs = 7'h7F;
                default:          rs = 7'($urandom_range(0, 127));
            endcase
            drive(ra, rs, $urandom_range(1, 10));
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        drive(4'hF, 7'h7F, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
Monitors a time-multiplexed, active-low 7-segment display bus (anode strobes plus shared segment lines). For each digit it reconstructs the hex nibble being displayed. This is the receiving end of the seg7 encode path: it maps segment pattern to nibble. It is used on-chip as a display read-back and self-check monitor, and in benches as a scoreboard tap.

Parameters:
NDIG, 4, number of digits / anode lines (2..8)
STABLE_CYC, 16, consecutive stable synchronized cycles required before a capture (>=1)
IDX_W, $clog2(NDIG), width of the digit index (derived; not overridden)

Ports:
clk  input  1  single system clock
rst  input  1  reset; synchronous, active-high
an  input  NDIG  anode strobes, active-low; bit i selects digit i
seg  input  7  segment lines, active-low; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g
value  output  4*NDIG  captured nibbles; digit i occupies value[4i+3:4i]
valid  output  NDIG  digit i holds a decoded hex value (0 = blank or never captured)
upd  output  1  one-cycle pulse: a capture occurred
upd_idx  output  IDX_W  digit index of the capture; meaningful only while upd=1
err  output  1  one-cycle pulse with upd: the pattern was neither a legal hex glyph nor blank
frame_done  output  1  one-cycle pulse: every digit has been captured at least once since the last frame_done

Behaviour:
- Reset (sync, active-high): value=0, valid=0, upd=0, upd_idx=0, err=0, frame_done=0, seen mask=0, stability counter=0, state=IDLE, synchronizer flops=all ones (idle bus). Reset takes priority over every other event, including a capture in progress.
- Input sync: an and seg each pass through two flops. The post-sync pair is {an_s, seg_s}.
- Stability: counter cnt clears whenever {an_s, seg_s} differs from its previous-cycle value. Otherwise cnt increments, saturating at STABLE_CYC.
- FSM:
  - IDLE: if an_s is exactly one-hot-low, go SETTLE. Otherwise (all high, or multiple low) stay.
  - SETTLE: if an_s is no longer one-hot-low, go IDLE. Else if cnt == STABLE_CYC-1 and the sample is unchanged, capture and go HOLD. Otherwise stay.
  - HOLD: any change of an_s goes to SETTLE (new one-hot) or IDLE. A seg_s change with the same an_s goes to SETTLE for the same digit (re-capture).
- Capture cycle: upd=1, upd_idx=index of the low anode, seen[idx]=1. Decode seg_s by inverse table (active-low, a..g):
  0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111,
  8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - Hit: nibble written to value[idx], valid[idx]=1, err=0.
  - Blank (1111111): valid[idx]=0, value[idx] unchanged, err=0.
  - Any other pattern: valid[idx]=0, value[idx] unchanged, err=1.
- Latency: a pin change held steady yields upd exactly 2+STABLE_CYC rising edges after the first edge that samples it. upd, err and frame_done are registered outputs.
- frame_done: asserted in the same cycle as the capture that completes seen == all ones. seen clears to 0 in that cycle, so the completing capture is not carried over. Re-captures of an already-seen digit do not advance the frame.
- A glitch shorter than STABLE_CYC cycles never captures. A strobe shorter than STABLE_CYC cycles yields no capture for that digit.
- Outputs hold between captures; no pulse lasts more than one cycle.

Decomposition:
- Package seg7_pkg: SEG_HEX[0:15] pattern constants, SEG_BLANK=7'b1111111, and FSM state enum {IDLE, SETTLE, HOLD}. The forward seg7 encoder should also reference these constants.
- One sub-module, seg7_inv: combinational seg[6:0] -> {hit, blank, nibble[3:0]}.
- Sync, stability counter, FSM and storage stay in the top.

Test Plan:
- NDIG=4, STABLE_CYC=4; from rst release drive an=1110, seg=0010010 and hold -> upd=1, upd_idx=0, value[3:0]=2, valid=0001, err=0, exactly 6 edges after first sample.
- Scan digits 0..3 with glyphs 7, A, d, F, each strobe 8 cycles -> four upd pulses; value=16'hFdA7, valid=1111; frame_done=1 coincident with the idx=3 upd only.
- an=1110, seg toggles 0000001/1001111 every 2 cycles -> no upd. Then hold 1001111 -> single upd with value[3:0]=1.
- an=1100 (two low) held 20 cycles -> no upd, FSM stays IDLE.
- Digit 2 shows illegal 1111110 -> upd=1, upd_idx=2, err=1, valid[2]=0, value[11:8] unchanged. Digit 2 then shows 1111111 -> err=0, valid[2]=0.
- Assert rst for one cycle during SETTLE (cnt=2) -> next cycle all outputs 0 and no upd for that strobe. Capture resumes 2+STABLE_CYC edges after release.
